// File: rtl/divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// with signs applied to the unsigned magnitudes in a final FINISH cycle.
module divider #(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_signed,
  input  logic [B-1:0] dividend,
  input  logic [B-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [B-1:0] quotient,
  output logic [B-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(B + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [B-1:0]   rem_q, rem_d;
  logic [B-1:0]   quo_q, quo_d;
  logic [B-1:0]   dsr_q, dsr_d;
  logic           sgn_q, sgn_d;
  logic           neg_dvd_q, neg_dvd_d;
  logic           neg_dsr_q, neg_dsr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [B-1:0]   quotient_q, quotient_d;
  logic [B-1:0]   remainder_q, remainder_d;
  logic           div_by_zero_q, div_by_zero_d;
  logic [B:0]     shifted_s;
  logic [B:0]     trial_s;
  logic           dbz_s;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dsr_d         = dsr_q;
    sgn_d         = sgn_q;
    neg_dvd_d     = neg_dvd_q;
    neg_dsr_d     = neg_dsr_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    // The partial remainder is always below the divisor, so B+1 bits hold the trial.
    shifted_s     = {rem_q, quo_q[B-1]};
    trial_s       = shifted_s - {1'b0, dsr_q};
    dbz_s         = (dsr_q == {B{1'b0}});

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          sgn_d     = is_signed;
          neg_dvd_d = is_signed & dividend[B-1];
          neg_dsr_d = is_signed & divisor[B-1];
          quo_d     = (is_signed & dividend[B-1]) ? (~dividend + {{(B-1){1'b0}}, 1'b1}) : dividend;
          dsr_d     = (is_signed & divisor[B-1])  ? (~divisor  + {{(B-1){1'b0}}, 1'b1}) : divisor;
          rem_d     = {B{1'b0}};
          cnt_d     = CW'(B);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!trial_s[B]) begin
          rem_d = trial_s[B-1:0];
          quo_d = {quo_q[B-2:0], 1'b1};
        end else begin
          rem_d = shifted_s[B-1:0];
          quo_d = {quo_q[B-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
        end else begin
          state_d = RUN;
        end
      end
      FINISH: begin
        // A zero divisor leaves the dividend magnitude in rem, so re-signing restores the input.
        if (dbz_s) begin
          quotient_d = {B{1'b1}};
        end else if (sgn_q & (neg_dvd_q ^ neg_dsr_q)) begin
          quotient_d = ~quo_q + {{(B-1){1'b0}}, 1'b1};
        end else begin
          quotient_d = quo_q;
        end
        if (sgn_q & neg_dvd_q) begin
          remainder_d = ~rem_q + {{(B-1){1'b0}}, 1'b1};
        end else begin
          remainder_d = rem_q;
        end
        div_by_zero_d = dbz_s;
        done_d        = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= {CW{1'b0}};
      rem_q         <= {B{1'b0}};
      quo_q         <= {B{1'b0}};
      dsr_q         <= {B{1'b0}};
      sgn_q         <= 1'b0;
      neg_dvd_q     <= 1'b0;
      neg_dsr_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= {B{1'b0}};
      remainder_q   <= {B{1'b0}};
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dsr_q         <= dsr_d;
      sgn_q         <= sgn_d;
      neg_dvd_q     <= neg_dvd_d;
      neg_dsr_q     <= neg_dsr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule
